uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 49 ++++
 rtl/uart_tx_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: state encoding,
// idle line level, supported data-width range and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   DATA_W_MIN = 5;
    localparam int   DATA_W_MAX = 9;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..per_lat-1 while enabled, a period of 0 is
// treated as 1. tick_next_o announces that the following cycle is a tick.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] per_lat_i,
    output logic             bit_tick_o,
    output logic             tick_next_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] per_m1_s;

    // Clamp the period, detect the tick and compute the next count.
    always_comb begin
        if (per_lat_i == {DIV_W{1'b0}}) begin
            per_m1_s = {DIV_W{1'b0}};
        end else begin
            per_m1_s = per_lat_i - DIV_W'(1);
        end
        bit_tick_o = enable_i && (cnt_q == per_m1_s);
        // After a tick the count restarts at 0, so the next cycle ticks only for a 1-cycle period.
        if (bit_tick_o) begin
            tick_next_o = (per_m1_s == {DIV_W{1'b0}});
        end else begin
            tick_next_o = enable_i && (cnt_q == per_m1_s - DIV_W'(1));
        end
        if (clear_i || !enable_i || bit_tick_o) begin
            cnt_d = {DIV_W{1'b0}};
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Asynchronous serial frame transmitter: start, DATA_W data bits LSB first,
// optional parity (macro UART_TX_PARITY_EN) and one or two stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DLY    = 1,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [DIV_W-1:0]  period_i,
    input  logic              stop2_i,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
`endif
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || DLY < 0) begin : g_bad_cfg
        $error("uart_tx_ctrl: unsupported parameter set");
    end

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              stop2_q, stop2_d;
    logic [DIV_W-1:0]  per_q, per_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`endif

    logic accept_s;
    logic bit_tick_s;
    logic tick_next_s;
    logic final_s;

    assign accept_s = tx_valid_i && ready_q;

    uart_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clear_i     (accept_s),
        .enable_i    (state_q != ST_IDLE),
        .per_lat_i   (per_q),
        .bit_tick_o  (bit_tick_s),
        .tick_next_o (tick_next_s)
    );

    // Frame sequencing, with the final stop-bit cycle already presented as IDLE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        stop2_d    = stop2_q;
        per_d      = per_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_START;
                    shift_d    = tx_data_i;
                    bit_idx_d  = 4'd0;
                    stop_idx_d = 1'b0;
                    stop2_d    = stop2_i;
                    per_d      = period_i;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = parity_en_i;
                    par_bit_d  = parity_bit(DATA_W_MAX'(tx_data_i), parity_odd_i);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s && bit_idx_q == 4'(DATA_W - 1)) begin
                    bit_idx_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                    state_d   = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_d   = ST_STOP;
`endif
                end else if (bit_tick_s) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    shift_d   = shift_q >> 1;
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s && stop2_q && !stop_idx_q) begin
                    stop_idx_d = 1'b1;
                end else if (bit_tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering the last cycle of the last stop bit: line stays high, frame reports done.
        final_s = (state_d == ST_STOP) && (!stop2_q || stop_idx_d) && tick_next_s;
        if (final_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end else begin
            done_d  = 1'b0;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_bit_q;
`endif
            default:   tx_d = IDLE_LEVEL;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= {DATA_W{1'b0}};
            bit_idx_q  <= 4'd0;
            stop_idx_q <= 1'b0;
            stop2_q    <= 1'b0;
            per_q      <= {DIV_W{1'b0}};
            tx_q       <= IDLE_LEVEL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            stop2_q    <= stop2_d;
            per_q      <= per_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl: table of single frames plus
// hand-written back-to-back, reset-abort and (if compiled in) parity sequences.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [15:0] period_i = 16'd0;
    logic        stop2_i = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = 8'd0;
    logic        tx_ready_o, tx_o, busy_o, done_o;
`ifdef UART_TX_PARITY_EN
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic tx_log    [0:127];
    logic done_log  [0:127];
    logic busy_log  [0:127];
    logic ready_log [0:127];

    typedef struct {
        logic [15:0] per;
        logic        s2;
        logic [7:0]  data;
        int          len;
        logic [11:0] bits;
    } vec_t;

    vec_t vecs [0:5];

    uart_tx_ctrl #(.DLY(1), .DATA_W(8), .DIV_W(16)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .period_i     (period_i),
        .stop2_i      (stop2_i),
`ifdef UART_TX_PARITY_EN
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
`endif
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one word, accept it, then log n cycles; inputs change mid-frame at cycle 1.
    task automatic send_and_log(input logic [15:0] per, input logic s2, input logic [7:0] d,
                                input int drop_at, input logic [15:0] cper, input logic cs2,
                                input logic [7:0] cd, input int n);
        @(negedge clk);
        chk("ready_before_accept", {31'd0, tx_ready_o}, 32'd1);
        period_i   = per;
        stop2_i    = s2;
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tx_log[k]    = tx_o;
            done_log[k]  = done_o;
            busy_log[k]  = busy_o;
            ready_log[k] = tx_ready_o;
            if (k == 1) begin
                period_i   = cper;
                stop2_i    = cs2;
                tx_data_i  = cd;
                tx_valid_i = (drop_at > 1);
            end
            if (k == drop_at) begin
                tx_valid_i = 1'b0;
            end
        end
        tx_valid_i = 1'b0;
    endtask

    function automatic int nth_done(input int nth, input int n);
        int seen = 0;
        for (int k = 1; k <= n; k++) begin
            if (done_log[k] === 1'b1) begin
                seen++;
                if (seen == nth) return k;
            end
        end
        return 0;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int pe, bad, dcount;
        pe = (v.per == 16'd0) ? 1 : int'(v.per);
        send_and_log(v.per, v.s2, v.data, 1, v.per + 16'd4, ~v.s2, ~v.data, v.len + 4);
        chk({tag, "_done_cycle"}, nth_done(1, v.len + 4), v.len);
        bad = 0;
        for (int k = 1; k <= v.len; k++) begin
            if (tx_log[k] !== v.bits[(k - 1) / pe]) bad++;
        end
        chk({tag, "_bit_errors"}, bad, 0);
        dcount = 0;
        for (int k = 1; k <= v.len + 4; k++) begin
            if (done_log[k] === 1'b1) dcount++;
        end
        chk({tag, "_done_pulses"}, dcount, 1);
        chk({tag, "_busy_first"}, {31'd0, busy_log[1]}, 32'd1);
        chk({tag, "_ready_first"}, {31'd0, ready_log[1]}, 32'd0);
        chk({tag, "_ready_at_done"}, {31'd0, ready_log[v.len]}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy_log[v.len]}, 32'd0);
        chk({tag, "_idle_after"}, {31'd0, tx_log[v.len + 2]}, 32'd1);
    endtask

    initial begin
        int d1, d2, dcount;

        vecs[0] = '{16'd4, 1'b0, 8'hA5, 40, {2'b00, 1'b1,  8'hA5, 1'b0}};
        vecs[1] = '{16'd0, 1'b0, 8'h3C, 10, {2'b00, 1'b1,  8'h3C, 1'b0}};
        vecs[2] = '{16'd1, 1'b0, 8'hC3, 10, {2'b00, 1'b1,  8'hC3, 1'b0}};
        vecs[3] = '{16'd3, 1'b1, 8'h5A, 33, {1'b0,  2'b11, 8'h5A, 1'b0}};
        vecs[4] = '{16'd2, 1'b0, 8'h00, 20, {2'b00, 1'b1,  8'h00, 1'b0}};
        vecs[5] = '{16'd5, 1'b1, 8'h81, 55, {1'b0,  2'b11, 8'h81, 1'b0}};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, tx_o}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // Back-to-back frames with valid held high.
        send_and_log(16'd2, 1'b0, 8'h00, 21, 16'd2, 1'b0, 8'hFF, 45);
        d1 = nth_done(1, 45);
        d2 = nth_done(2, 45);
        chk("b2b_first_done", d1, 20);
        chk("b2b_done_spacing", d2 - d1, 20);
        chk("b2b_first_data", {31'd0, tx_log[3]}, 32'd0);
        chk("b2b_last_stop", {31'd0, tx_log[20]}, 32'd1);
        chk("b2b_second_start", {31'd0, tx_log[21]}, 32'd0);
        chk("b2b_second_data", {31'd0, tx_log[23]}, 32'd1);
        repeat (4) @(negedge clk);

        // Reset while shifting data bits abandons the frame.
        send_and_log(16'd4, 1'b0, 8'hA5, 1, 16'd4, 1'b0, 8'hA5, 10);
        chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
        rstn_i = 1'b0;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx_o}, 32'd1);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_ready", {31'd0, tx_ready_o}, 32'd1);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        rstn_i = 1'b1;
        dcount = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        run_vec(vecs[0], "after_abort");
        repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        send_and_log(16'd1, 1'b0, 8'h07, 1, 16'd1, 1'b0, 8'h07, 15);
        chk("par_even_done", nth_done(1, 15), 11);
        chk("par_even_bit", {31'd0, tx_log[10]}, 32'd1);
        repeat (2) @(negedge clk);
        parity_odd_i = 1'b1;
        send_and_log(16'd1, 1'b0, 8'h07, 1, 16'd1, 1'b0, 8'h07, 15);
        chk("par_odd_done", nth_done(1, 15), 11);
        chk("par_odd_bit", {31'd0, tx_log[10]}, 32'd0);
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
